// File: rtl/axis_check_packet.sv
// Receive-side packet checker: compares each accepted AXI-Stream beat against a fixed
// message, checks the packet length, and reports a registered one-cycle verdict per packet.
module axis_check_packet #(
    parameter int                   DW      = 8,
    parameter int                   MSG_LEN = 2,
    parameter logic [8*MSG_LEN-1:0] MSG_STR = "aa",
    parameter int                   CW      = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [DW-1:0] i_msg_data,
    input  logic          i_msg_last,
    input  logic          i_msg_valid,
    output logic          o_msg_ready,
    input  logic          i_ready_en,
    output logic          o_done,
    output logic          o_match,
    output logic          o_err_data,
    output logic          o_err_len,
    output logic [CW-1:0] o_pkt_cnt,
    output logic [CW-1:0] o_err_cnt
);
    // state  | meaning
    // RECV   | accepting beats of the current packet, accumulating error flags
    // RECV   | (idx saturates at MSG_LEN so over-long packets keep flagging)
    // REPORT | single verdict cycle, ready held low, idx and flags cleared
    localparam int IW = $clog2(MSG_LEN + 1);

    typedef enum logic {
        RECV   = 1'b0,
        REPORT = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] idx;
    logic          flag_data, flag_len;
    logic          accept;
    logic          over, short_pkt, hi_nz;
    logic          beat_err_data, beat_err_len;
    logic          fin_data, fin_len;
    logic [7:0]    exp_char;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= RECV;
        else       state <= state_nxt;
    end

    // Ready is gated by reset so it stays low while reset is held.
    always_comb begin
        state_nxt   = state;
        o_msg_ready = 1'b0;
        case (state)
            RECV: begin
                o_msg_ready = i_ready_en & ~i_rst;
                if (o_msg_ready && i_msg_valid && i_msg_last) state_nxt = REPORT;
            end
            REPORT:  state_nxt = RECV;
            default: state_nxt = RECV;
        endcase
    end

    assign accept = o_msg_ready & i_msg_valid;

    generate
        if (DW > 8) begin : g_hi
            assign hi_nz = |i_msg_data[DW-1:8];
        end else begin : g_no_hi
            assign hi_nz = 1'b0;
        end
    endgenerate

    always_comb begin
        exp_char = 8'h00;
        for (int i = 0; i < MSG_LEN; i++) begin
            if (idx == IW'(i)) exp_char = MSG_STR[8*(MSG_LEN-i)-1 -: 8];
        end
    end

    assign over          = (idx >= IW'(MSG_LEN));
    assign short_pkt     = i_msg_last & (idx < IW'(MSG_LEN - 1));
    assign beat_err_data = (i_msg_data[7:0] != exp_char) | hi_nz | over;
    assign beat_err_len  = over | short_pkt;
    assign fin_data      = flag_data | beat_err_data;
    assign fin_len       = flag_len | beat_err_len;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            idx        <= '0;
            flag_data  <= 1'b0;
            flag_len   <= 1'b0;
            o_done     <= 1'b0;
            o_match    <= 1'b0;
            o_err_data <= 1'b0;
            o_err_len  <= 1'b0;
            o_pkt_cnt  <= '0;
            o_err_cnt  <= '0;
        end else begin
            o_done <= 1'b0;
            if (state == REPORT) begin
                idx       <= '0;
                flag_data <= 1'b0;
                flag_len  <= 1'b0;
            end else if (accept) begin
                if (!over) idx <= idx + IW'(1);
                flag_data <= fin_data;
                flag_len  <= fin_len;
                if (i_msg_last) begin
                    o_done     <= 1'b1;
                    o_err_data <= fin_data;
                    o_err_len  <= fin_len;
                    o_match    <= ~(fin_data | fin_len);
                    o_pkt_cnt  <= o_pkt_cnt + CW'(1);
                    if (fin_data | fin_len) o_err_cnt <= o_err_cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_axis_check_packet.sv
// Scoreboard bench for axis_check_packet: stimulus pushes expected verdicts, a monitor
// pops and compares on every o_done pulse.
module tb_axis_check_packet;
    localparam int DW      = 16;
    localparam int MSG_LEN = 3;
    localparam int CW      = 2;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic [DW-1:0] i_msg_data;
    logic          i_msg_last;
    logic          i_msg_valid;
    logic          o_msg_ready;
    logic          i_ready_en;
    logic          o_done, o_match, o_err_data, o_err_len;
    logic [CW-1:0] o_pkt_cnt, o_err_cnt;

    axis_check_packet #(
        .DW(DW), .MSG_LEN(MSG_LEN), .MSG_STR("abc"), .CW(CW)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_msg_data(i_msg_data), .i_msg_last(i_msg_last),
        .i_msg_valid(i_msg_valid), .o_msg_ready(o_msg_ready), .i_ready_en(i_ready_en),
        .o_done(o_done), .o_match(o_match), .o_err_data(o_err_data), .o_err_len(o_err_len),
        .o_pkt_cnt(o_pkt_cnt), .o_err_cnt(o_err_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit match;
        bit ed;
        bit el;
        int pkt;
        int err;
        int beats;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   m_pkt = 0;
    int   m_err = 0;
    bit   bp_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int   bp_k = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: verdict must follow the last-beat handshake by exactly one cycle.
    bit pending = 1'b0;
    int beats   = 0;
    always @(negedge i_clk) begin
        if (i_rst) begin
            pending = 1'b0;
            beats   = 0;
        end else begin
            if (pending) check("done_latency", int'(o_done), 1);
            if (o_done) begin
                if (!pending) check("spurious_done", int'(o_done), 0);
                if (sbq.size() == 0) begin
                    check("unexpected_done", int'(o_done), 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("match", int'(o_match), int'(e.match));
                    check("err_data", int'(o_err_data), int'(e.ed));
                    check("err_len", int'(o_err_len), int'(e.el));
                    check("pkt_cnt", int'(o_pkt_cnt), e.pkt);
                    check("err_cnt", int'(o_err_cnt), e.err);
                    check("beats_accepted", beats, e.beats);
                    check("ready_in_report", int'(o_msg_ready), 0);
                end
                beats = 0;
            end
            pending = i_msg_valid && o_msg_ready && i_msg_last;
            if (i_msg_valid && o_msg_ready) beats++;
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic l, input bit bp, output int waited);
        bit hs;
        waited      = 0;
        i_msg_data  = d;
        i_msg_last  = l;
        i_msg_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (bp) begin
                i_ready_en = bp_pat[bp_k % 4];
                bp_k++;
            end else begin
                i_ready_en = 1'b1;
            end
            @(negedge i_clk);
            hs = o_msg_ready;
            @(posedge i_clk);
            #1;
            waited++;
            if (hs) return;
        end
        total++;
        bad++;
        $display("FAIL beat_timeout: no handshake after %0d cycles, required within 20", waited);
    endtask

    task automatic send_pkt(input string s, input logic [DW-1:0] or0, input bit bp,
                            input bit ed, input bit el, output int cycles, output int first_wait);
        exp_t e;
        int   w;
        m_pkt = (m_pkt + 1) % 4;
        if (ed || el) m_err = (m_err + 1) % 4;
        e.match = !(ed || el);
        e.ed    = ed;
        e.el    = el;
        e.pkt   = m_pkt;
        e.err   = m_err;
        e.beats = s.len();
        sbq.push_back(e);
        cycles     = 0;
        first_wait = 0;
        for (int k = 0; k < s.len(); k++) begin
            send_beat({8'h00, s[k]} | ((k == 0) ? or0 : '0), k == s.len() - 1, bp, w);
            if (k == 0) first_wait = w;
            cycles += w;
        end
    endtask

    task automatic idle(input int n);
        i_msg_valid = 1'b0;
        i_ready_en  = 1'b1;
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_ready", int'(o_msg_ready), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_match", int'(o_match), 0);
        check("rst_err_data", int'(o_err_data), 0);
        check("rst_err_len", int'(o_err_len), 0);
        check("rst_pkt_cnt", int'(o_pkt_cnt), 0);
        check("rst_err_cnt", int'(o_err_cnt), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, w;
        i_rst       = 1'b1;
        i_msg_valid = 1'b0;
        i_msg_data  = '0;
        i_msg_last  = 1'b0;
        i_ready_en  = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        check_reset_outputs();
        i_rst = 1'b0;
        #1;
        check("ready_after_reset", int'(o_msg_ready), 1);

        send_pkt("abc", '0, 1'b0, 1'b0, 1'b0, c, w);        // good
        check("good_cycles", c, 3);
        idle(2);
        send_pkt("abd", '0, 1'b0, 1'b1, 1'b0, c, w);        // data mismatch
        idle(2);
        send_pkt("ab", '0, 1'b0, 1'b0, 1'b1, c, w);         // short
        idle(2);
        send_pkt("abcx", '0, 1'b0, 1'b1, 1'b1, c, w);       // long, 4 beats
        idle(2);
        send_pkt("abc", 16'h0100, 1'b0, 1'b1, 1'b0, c, w);  // nonzero upper data bits
        idle(2);
        send_pkt("abc", '0, 1'b1, 1'b0, 1'b0, c, w);        // ready_en 1,0,0,1,1
        check("bp_cycles", c, 5);
        idle(2);

        // Second packet's first beat is offered during REPORT and must wait one cycle.
        send_pkt("abc", '0, 1'b0, 1'b0, 1'b0, c, w);
        send_pkt("abc", '0, 1'b0, 1'b0, 1'b0, c, w);
        check("report_hold_wait", w, 2);
        check("b2b_cycles", c, 4);
        idle(2);

        // Reset after one beat: partial packet discarded, counters back to zero.
        send_beat({8'h00, 8'h61}, 1'b0, 1'b0, w);
        i_msg_valid = 1'b0;
        i_rst       = 1'b1;
        #1;
        check_reset_outputs();
        m_pkt = 0;
        m_err = 0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        idle(1);

        // Five good packets: pkt_cnt runs 1,2,3,0,1 with CW=2.
        for (int p = 0; p < 5; p++) begin
            send_pkt("abc", '0, 1'b0, 1'b0, 1'b0, c, w);
            idle(1);
        end
        idle(3);
        check("sb_drained", sbq.size(), 0);
        check("final_pkt_cnt", int'(o_pkt_cnt), 1);
        check("final_err_cnt", int'(o_err_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
